pipe_stage_reg: RTL

- Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
- Intended as the generic successor of the fixed stage registers between MEM/WB and other stages. Carries a write-enable, a select field, a write address and a data payload.
- Downstream stalls never corrupt the payload. Bubbles never raise a write-enable.

---
 rtl/pipe_stage_reg_pkg.sv | 14 +
 rtl/pipe_stage_entry.sv | 29 ++
 rtl/pipe_stage_reg.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline stage register:
// writeback-select encodings and default datapath widths.
package pipe_stage_reg_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_PC4  = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot: a valid bit plus the packed {wen, sel, wa, data} word.
// Clear only drops the valid bit; the word keeps its last contents.
module pipe_stage_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int W = 104
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// an optional 2-entry skid buffer (main entry M, skid entry S, FIFO order).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 3 * XLEN,
    parameter int SEL_W  = $bits(wb_sel_e),
    parameter int WA_W   = REG_AW,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [WA_W-1:0]   in_wa,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wen,
    output logic [SEL_W-1:0]  out_sel,
    output logic [WA_W-1:0]   out_wa,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    localparam int W = 1 + SEL_W + WA_W + DATA_W;

    logic [W-1:0] in_word, m_d, m_q;
    logic         m_vld, s_vld, m_load, m_clr;
    logic         in_xfer, out_xfer;

    assign in_word  = {in_wen, in_sel, in_wa, in_data};
    assign in_xfer  = in_valid & in_ready & ~flush;
    assign out_xfer = m_vld & out_ready;

    assign out_valid = m_vld;
    assign out_wen   = m_q[W-1] & m_vld;
    assign out_sel   = m_q[DATA_W+WA_W +: SEL_W];
    assign out_wa    = m_q[DATA_W +: WA_W];
    assign out_data  = m_q[DATA_W-1:0];
    assign occ       = {1'b0, m_vld} + {1'b0, s_vld};

    pipe_stage_entry #(.W(W)) u_main (
        .CLK   (CLK),
        .RST   (RST),
        .load  (m_load),
        .clear (m_clr),
        .d     (m_d),
        .valid (m_vld),
        .q     (m_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic [W-1:0] s_q;
            logic         s_load, s_clr, rdy_q, full_next;

            pipe_stage_entry #(.W(W)) u_skid (
                .CLK   (CLK),
                .RST   (RST),
                .load  (s_load),
                .clear (s_clr),
                .d     (in_word),
                .valid (s_vld),
                .q     (s_q)
            );

            always_comb begin
                m_d    = in_word;
                m_load = 1'b0;
                m_clr  = 1'b0;
                s_load = 1'b0;
                s_clr  = 1'b0;
                if (flush) begin
                    m_clr = 1'b1;
                    s_clr = 1'b1;
                end else if (!m_vld) begin
                    m_load = in_xfer;
                end else if (!s_vld) begin
                    if (in_xfer && out_xfer)  m_load = 1'b1;
                    else if (out_xfer)        m_clr  = 1'b1;
                    else if (in_xfer)         s_load = 1'b1;
                end else if (out_xfer) begin
                    // S drains into M so the older entry always leaves first
                    m_d    = s_q;
                    m_load = 1'b1;
                    s_clr  = 1'b1;
                end
            end

            assign full_next = ~flush & m_vld & ~out_xfer & (s_vld | in_xfer);

            // Registered ready keeps out_ready off the upstream timing path
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) rdy_q <= 1'b1;
                else     rdy_q <= ~full_next;
            end

            assign in_ready = rdy_q | flush;
        end else begin : g_single
            assign s_vld    = 1'b0;
            assign in_ready = ~m_vld | out_ready | flush;

            always_comb begin
                m_d    = in_word;
                m_load = in_xfer;
                m_clr  = flush | (out_xfer & ~in_xfer);
            end
        end
    endgenerate

endmodule
